// File: rtl/pwm_timebase.sv
// PWM carrier timebase: sawtooth or centre-aligned triangle counter with a
// shadowed period, external sync restart and registered terminal/zero flags.
module pwm_timebase #(
  parameter int WIDTH = 11,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic             period_load,
  input  logic             sync,
  output logic [WIDTH-1:0] counter,
  output logic             dir,
  output logic             tc,
  output logic             zero,
  output logic [WIDTH-1:0] active_period
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] stg_q, stg_d;
  logic             pend_q, pend_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             zero_q, zero_d;
  logic             boundary;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    act_d    = act_q;
    stg_d    = stg_q;
    pend_d   = pend_q;
    boundary = 1'b0;

    if (sync) begin
      cnt_d    = '0;
      dir_d    = 1'b1;
      boundary = 1'b1;
    end else if (enable) begin
      if (MODE == 0) begin
        if (cnt_q == act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (act_q == '0) begin
        cnt_d    = '0;
        dir_d    = 1'b1;
        boundary = 1'b1;
      end else if (dir_q) begin
        cnt_d = cnt_inc;
        if (cnt_inc == act_q) dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          dir_d    = 1'b1;
          boundary = 1'b1;
        end
      end
    end

    // Reload uses the value staged before this edge; a coincident strobe
    // lands in staging and waits for the following boundary.
    if (boundary && pend_q) begin
      act_d  = stg_q;
      pend_d = 1'b0;
    end
    if (period_load) begin
      stg_d  = period;
      pend_d = 1'b1;
    end
  end

  // Flags are derived from next state so they line up with the registered count.
  assign tc_d   = (cnt_d == act_d);
  assign zero_d = (cnt_d == '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      act_q  <= period;
      stg_q  <= period;
      pend_q <= 1'b0;
      zero_q <= 1'b1;
      tc_q   <= (period == '0);
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      act_q  <= act_d;
      stg_q  <= stg_d;
      pend_q <= pend_d;
      zero_q <= zero_d;
      tc_q   <= tc_d;
    end
  end

  assign counter       = cnt_q;
  assign dir           = dir_q;
  assign tc            = tc_q;
  assign zero          = zero_q;
  assign active_period = act_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: sawtooth and triangle instances on shared stimulus,
// each checked every cycle against a phase-based carrier model.
module tb_pwm_timebase;

  typedef struct {
    int k;     // phase within the carrier cycle, 0 .. len-1
    int act;
    int stg;
    bit pend;
  } model_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] period = '0;
  logic        period_load = 1'b0;
  logic        sync = 1'b0;

  logic [10:0] s_counter, s_active, t_counter, t_active;
  logic        s_dir, s_tc, s_zero, t_dir, t_tc, t_zero;
  logic [24:0] s_obs, t_obs;

  model_t ms, mt;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pwm_timebase #(.WIDTH(11), .MODE(0)) u_saw (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .period_load(period_load), .sync(sync), .counter(s_counter), .dir(s_dir),
    .tc(s_tc), .zero(s_zero), .active_period(s_active)
  );

  pwm_timebase #(.WIDTH(11), .MODE(1)) u_tri (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .period_load(period_load), .sync(sync), .counter(t_counter), .dir(t_dir),
    .tc(t_tc), .zero(t_zero), .active_period(t_active)
  );

  assign s_obs = {s_counter, s_dir, s_tc, s_zero, s_active};
  assign t_obs = {t_counter, t_dir, t_tc, t_zero, t_active};

  function automatic int carrier_len(model_t m, int mode);
    if (mode == 0) return m.act + 1;
    return (m.act == 0) ? 1 : 2 * m.act;
  endfunction

  function automatic model_t step_model(model_t m, int mode, bit r, bit en,
                                        bit s, bit ld, int p);
    model_t n = m;
    bit bnd = 1'b0;
    if (r) begin
      n.k = 0; n.act = p; n.stg = p; n.pend = 1'b0;
      return n;
    end
    if (s) begin
      n.k = 0; bnd = 1'b1;
    end else if (en) begin
      n.k = m.k + 1;
      if (n.k == carrier_len(m, mode)) begin
        n.k = 0; bnd = 1'b1;
      end
    end
    if (bnd && m.pend) begin
      n.act = m.stg; n.pend = 1'b0;
    end
    if (ld) begin
      n.stg = p; n.pend = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [24:0] exp_pack(model_t m, int mode);
    int c;
    bit d;
    if (mode == 0) begin
      c = m.k; d = 1'b1;
    end else begin
      c = (m.k <= m.act) ? m.k : 2 * m.act - m.k;
      d = (m.act == 0) ? 1'b1 : (m.k < m.act);
    end
    return {11'(c), d, (c == m.act), (c == 0), 11'(m.act)};
  endfunction

  // Applies one clock of stimulus and advances both models.
  task automatic tick(input bit r, input bit en, input bit s, input bit ld,
                      input logic [10:0] p);
    reset = r; enable = en; sync = s; period_load = ld; period = p;
    @(posedge clk);
    ms = step_model(ms, 0, r, en, s, ld, int'(p));
    mt = step_model(mt, 1, r, en, s, ld, int'(p));
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 11'd4);
    n_vec++;
    if (s_obs !== exp_pack(ms, 0)) begin
      n_err++; $display("FAIL reset_saw cyc=%0d got=%h exp=%h", cyc, s_obs, exp_pack(ms, 0));
    end
    n_vec++;
    if (t_obs !== exp_pack(mt, 1)) begin
      n_err++; $display("FAIL reset_tri cyc=%0d got=%h exp=%h", cyc, t_obs, exp_pack(mt, 1));
    end
    n_vec++;
    if ({s_counter, s_zero, s_tc, s_active} !== {11'd0, 1'b1, 1'b0, 11'd4}) begin
      n_err++; $display("FAIL reset_const cyc=%0d got=%h exp=%h", cyc,
                        {s_counter, s_zero, s_tc, s_active}, {11'd0, 1'b1, 1'b0, 11'd4});
    end
  endtask

  task automatic test_sawtooth();
    int tc_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      if (s_tc) tc_cnt++;
      n_vec++;
      if (s_obs !== exp_pack(ms, 0)) begin
        n_err++; $display("FAIL sawtooth cyc=%0d got=%h exp=%h", cyc, s_obs, exp_pack(ms, 0));
      end
    end
    n_vec++;
    if (tc_cnt !== 3) begin
      n_err++; $display("FAIL sawtooth_tc_count got=%0d exp=3", tc_cnt);
    end
  endtask

  task automatic test_triangle();
    tick(1, 0, 0, 0, 11'd3);
    for (int i = 0; i < 14; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      n_vec++;
      if (t_obs !== exp_pack(mt, 1)) begin
        n_err++; $display("FAIL triangle cyc=%0d got=%h exp=%h", cyc, t_obs, exp_pack(mt, 1));
      end
    end
  endtask

  task automatic test_shadow_reload();
    tick(1, 0, 0, 0, 11'd10);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 11'd0);
    tick(0, 1, 0, 1, 11'd3);
    tick(0, 1, 0, 0, 11'd0);
    tick(0, 1, 0, 1, 11'd7);
    for (int i = 0; i < 22; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      n_vec++;
      if (s_obs !== exp_pack(ms, 0)) begin
        n_err++; $display("FAIL shadow_saw cyc=%0d got=%h exp=%h", cyc, s_obs, exp_pack(ms, 0));
      end
      n_vec++;
      if (t_obs !== exp_pack(mt, 1)) begin
        n_err++; $display("FAIL shadow_tri cyc=%0d got=%h exp=%h", cyc, t_obs, exp_pack(mt, 1));
      end
    end
  endtask

  task automatic test_sync();
    tick(1, 0, 0, 0, 11'd8);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, (i == 3), 11'd2);
    tick(0, 1, 1, 0, 11'd0);
    n_vec++;
    if ({t_counter, t_dir, t_active} !== {11'd0, 1'b1, 11'd2}) begin
      n_err++; $display("FAIL sync_restart cyc=%0d got=%h exp=%h", cyc,
                        {t_counter, t_dir, t_active}, {11'd0, 1'b1, 11'd2});
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      n_vec++;
      if (t_obs !== exp_pack(mt, 1)) begin
        n_err++; $display("FAIL sync_tri cyc=%0d got=%h exp=%h", cyc, t_obs, exp_pack(mt, 1));
      end
    end
  endtask

  task automatic test_enable_reset();
    tick(1, 0, 0, 0, 11'd10);
    for (int i = 0; i < 7; i++) tick(0, 1, 0, 0, 11'd0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, (i == 1), 11'd5);
      n_vec++;
      if ({s_counter, s_tc, s_zero} !== {11'd7, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL hold_saw cyc=%0d got=%h exp=%h", cyc,
                          {s_counter, s_tc, s_zero}, {11'd7, 1'b0, 1'b0});
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      n_vec++;
      if (s_obs !== exp_pack(ms, 0)) begin
        n_err++; $display("FAIL resume_saw cyc=%0d got=%h exp=%h", cyc, s_obs, exp_pack(ms, 0));
      end
    end
    tick(1, 1, 1, 1, 11'd6);
    n_vec++;
    if ({s_obs, t_obs} !== {exp_pack(ms, 0), exp_pack(mt, 1)}) begin
      n_err++; $display("FAIL reset_sync_load cyc=%0d got=%h exp=%h", cyc,
                        {s_obs, t_obs}, {exp_pack(ms, 0), exp_pack(mt, 1)});
    end
    n_vec++;
    if (s_active !== 11'd6) begin
      n_err++; $display("FAIL reset_active got=%0d exp=6", s_active);
    end
  endtask

  task automatic test_degenerate();
    int max_seen = 0;
    tick(1, 0, 0, 0, 11'd0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, (i == 3), 11'd2);
      n_vec++;
      if ({s_obs, t_obs} !== {exp_pack(ms, 0), exp_pack(mt, 1)}) begin
        n_err++; $display("FAIL p0 cyc=%0d got=%h exp=%h", cyc,
                          {s_obs, t_obs}, {exp_pack(ms, 0), exp_pack(mt, 1)});
      end
    end
    tick(1, 0, 0, 0, 11'd2047);
    for (int i = 0; i < 2052; i++) begin
      tick(0, 1, 0, 0, 11'd0);
      if (int'(s_counter) > max_seen) max_seen = int'(s_counter);
      n_vec++;
      if ({s_obs, t_obs} !== {exp_pack(ms, 0), exp_pack(mt, 1)}) begin
        n_err++; $display("FAIL pmax cyc=%0d got=%h exp=%h", cyc,
                          {s_obs, t_obs}, {exp_pack(ms, 0), exp_pack(mt, 1)});
      end
    end
    n_vec++;
    if (max_seen !== 2047) begin
      n_err++; $display("FAIL pmax_peak got=%0d exp=2047", max_seen);
    end
  endtask

  task automatic test_random();
    bit r, en, s, ld;
    logic [10:0] p;
    tick(1, 0, 0, 0, 11'd5);
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 80);
      ld = ($urandom_range(0, 99) < 10);
      s  = !ld && ($urandom_range(0, 99) < 3);
      p  = ($urandom_range(0, 99) < 2) ? 11'($urandom_range(0, 2047))
                                       : 11'($urandom_range(0, 12));
      tick(r, en, s, ld, p);
      n_vec++;
      if ({s_obs, t_obs} !== {exp_pack(ms, 0), exp_pack(mt, 1)}) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                          {s_obs, t_obs}, {exp_pack(ms, 0), exp_pack(mt, 1)});
      end
    end
  endtask

  initial begin
    ms = '{k: 0, act: 0, stg: 0, pend: 1'b0};
    mt = '{k: 0, act: 0, stg: 0, pend: 1'b0};
    @(negedge clk);
    test_reset();
    test_sawtooth();
    test_triangle();
    test_shadow_reload();
    test_sync();
    test_enable_reset();
    test_degenerate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
